// File: rtl/operand_collector_pkg.sv
// Shared ISA encodings and the per-opcode operand/source-use decode for the operand collector.
package operand_collector_pkg;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_REGIMM  = 6'h01;
  localparam logic [5:0] OPC_J       = 6'h02;
  localparam logic [5:0] OPC_JAL     = 6'h03;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_BNE     = 6'h05;
  localparam logic [5:0] OPC_BLEZ    = 6'h06;
  localparam logic [5:0] OPC_BGTZ    = 6'h07;
  localparam logic [5:0] OPC_ADDI    = 6'h08;
  localparam logic [5:0] OPC_ADDIU   = 6'h09;
  localparam logic [5:0] OPC_SLTI    = 6'h0a;
  localparam logic [5:0] OPC_SLTIU   = 6'h0b;
  localparam logic [5:0] OPC_ANDI    = 6'h0c;
  localparam logic [5:0] OPC_ORI     = 6'h0d;
  localparam logic [5:0] OPC_XORI    = 6'h0e;
  localparam logic [5:0] OPC_LUI     = 6'h0f;
  localparam logic [5:0] OPC_LB      = 6'h20;
  localparam logic [5:0] OPC_LH      = 6'h21;
  localparam logic [5:0] OPC_LWL     = 6'h22;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_LBU     = 6'h24;
  localparam logic [5:0] OPC_LHU     = 6'h25;
  localparam logic [5:0] OPC_LWR     = 6'h26;
  localparam logic [5:0] OPC_SB      = 6'h28;
  localparam logic [5:0] OPC_SH      = 6'h29;
  localparam logic [5:0] OPC_SWL     = 6'h2a;
  localparam logic [5:0] OPC_SW      = 6'h2b;
  localparam logic [5:0] OPC_SWR     = 6'h2e;

  localparam logic [5:0] FUN_SLL = 6'h00;
  localparam logic [5:0] FUN_SRL = 6'h02;
  localparam logic [5:0] FUN_SRA = 6'h03;

  typedef enum logic [1:0] {OPA_RS, OPA_SHAMT, OPA_ZERO} opa_sel_e;
  typedef enum logic [1:0] {OPB_ZERO, OPB_RT, OPB_SIMM, OPB_ZIMM} opb_sel_e;

  typedef struct packed {
    logic     uses_rs;
    logic     uses_rt;
    opa_sel_e opa_sel;
    opb_sel_e opb_sel;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [5:0] opc;
    logic [5:0] fun;
    logic       is_shift;
    opc      = instr[31:26];
    fun      = instr[5:0];
    is_shift = (opc == OPC_SPECIAL) && (fun inside {FUN_SLL, FUN_SRL, FUN_SRA});
    d.uses_rs = !((opc inside {OPC_J, OPC_JAL, OPC_LUI}) || is_shift);
    d.uses_rt = opc inside {OPC_SPECIAL, OPC_BEQ, OPC_BNE, OPC_SB, OPC_SH, OPC_SW};
    if (is_shift)                         d.opa_sel = OPA_SHAMT;
    else if (opc inside {OPC_J, OPC_JAL}) d.opa_sel = OPA_ZERO;
    else                                  d.opa_sel = OPA_RS;
    case (opc)
      OPC_SPECIAL, OPC_BEQ, OPC_BNE:                      d.opb_sel = OPB_RT;
      OPC_ADDI, OPC_ADDIU, OPC_SLTI, OPC_SLTIU,
      OPC_LB, OPC_LH, OPC_LWL, OPC_LW, OPC_LBU, OPC_LHU, OPC_LWR,
      OPC_SB, OPC_SH, OPC_SWL, OPC_SW, OPC_SWR:           d.opb_sel = OPB_SIMM;
      OPC_ANDI, OPC_ORI, OPC_XORI, OPC_LUI:               d.opb_sel = OPB_ZIMM;
      default:                                            d.opb_sel = OPB_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/operand_collector_fwd_resolve.sv
// Resolves one source register against the bypass channels; the youngest matching channel wins.
module operand_collector_fwd_resolve #(
  parameter int WIDTH    = 32,
  parameter int NUM_FWD  = 3,
  parameter int REG_BITS = 5
) (
  input  logic [REG_BITS-1:0]         src_i,
  input  logic [WIDTH-1:0]            rf_data_i,
  input  logic [NUM_FWD-1:0]          fwd_valid_i,
  input  logic [NUM_FWD*REG_BITS-1:0] fwd_reg_i,
  input  logic [NUM_FWD-1:0]          fwd_avail_i,
  input  logic [NUM_FWD*WIDTH-1:0]    fwd_data_i,
  output logic [WIDTH-1:0]            data_o,
  output logic                        hazard_o
);

  logic hit;

  // Once a channel hits, older channels are ignored, so an older ready copy cannot hide a pending load.
  always_comb begin
    data_o   = rf_data_i;
    hazard_o = 1'b0;
    hit      = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!hit && fwd_valid_i[i] && (src_i != '0) &&
          (fwd_reg_i[i*REG_BITS +: REG_BITS] == src_i)) begin
        hit      = 1'b1;
        data_o   = fwd_data_i[i*WIDTH +: WIDTH];
        hazard_o = !fwd_avail_i[i];
      end
    end
  end

endmodule

// File: rtl/operand_collector.sv
// ID/EX operand stage: bypass resolution, load-use stall detection and a valid/ready pipeline slot.
module operand_collector
  import operand_collector_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_FWD  = 3,
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 instruction,
  input  logic [WIDTH-1:0]            rsData,
  input  logic [WIDTH-1:0]            rtData,
  input  logic [WIDTH-1:0]            extendedImm,
  input  logic [NUM_FWD-1:0]          fwd_valid,
  input  logic [NUM_FWD*REG_BITS-1:0] fwd_reg,
  input  logic [NUM_FWD-1:0]          fwd_avail,
  input  logic [NUM_FWD*WIDTH-1:0]    fwd_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_instruction,
  output logic [WIDTH-1:0]            opA,
  output logic [WIDTH-1:0]            opB,
  output logic [WIDTH-1:0]            writeToMemData,
  output logic [CNT_BITS-1:0]         stall_count
);

  dec_t             dec;
  logic [WIDTH-1:0] rs_res, rt_res;
  logic             rs_haz, rt_haz, hazard, capture;
  logic [WIDTH-1:0] opa_new, opb_new;

  logic                valid_q, valid_d;
  logic [31:0]         instr_q, instr_d;
  logic [WIDTH-1:0]    opa_q, opa_d, opb_q, opb_d, wmd_q, wmd_d;
  logic [CNT_BITS-1:0] stall_q, stall_d;

  assign dec = decode(instruction);

  operand_collector_fwd_resolve #(.WIDTH(WIDTH), .NUM_FWD(NUM_FWD), .REG_BITS(REG_BITS)) u_rs (
    .src_i(REG_BITS'(instruction[25:21])), .rf_data_i(rsData),
    .fwd_valid_i(fwd_valid), .fwd_reg_i(fwd_reg), .fwd_avail_i(fwd_avail), .fwd_data_i(fwd_data),
    .data_o(rs_res), .hazard_o(rs_haz)
  );

  operand_collector_fwd_resolve #(.WIDTH(WIDTH), .NUM_FWD(NUM_FWD), .REG_BITS(REG_BITS)) u_rt (
    .src_i(REG_BITS'(instruction[20:16])), .rf_data_i(rtData),
    .fwd_valid_i(fwd_valid), .fwd_reg_i(fwd_reg), .fwd_avail_i(fwd_avail), .fwd_data_i(fwd_data),
    .data_o(rt_res), .hazard_o(rt_haz)
  );

  // Only sources the opcode actually reads can stall it.
  assign hazard   = (dec.uses_rs && rs_haz) || (dec.uses_rt && rt_haz);
  assign in_ready = !hazard && (!valid_q || out_ready);
  assign capture  = in_valid && in_ready && !flush;

  always_comb begin
    opa_new = rs_res;
    case (dec.opa_sel)
      OPA_SHAMT: opa_new = WIDTH'(instruction[10:6]);
      OPA_ZERO:  opa_new = '0;
      default:   opa_new = rs_res;
    endcase
    opb_new = '0;
    case (dec.opb_sel)
      OPB_RT:   opb_new = rt_res;
      OPB_SIMM: opb_new = extendedImm;
      OPB_ZIMM: opb_new = WIDTH'(extendedImm[15:0]);
      default:  opb_new = '0;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    wmd_d   = wmd_q;
    stall_d = stall_q;
    if (flush)          valid_d = 1'b0;
    else if (capture)   valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
    if (capture) begin
      instr_d = instruction;
      opa_d   = opa_new;
      opb_d   = opb_new;
      wmd_d   = rt_res;
    end
    if (in_valid && hazard && !flush && (stall_q != '1))
      stall_d = stall_q + CNT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      wmd_q   <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      wmd_q   <= wmd_d;
      stall_q <= stall_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_instruction = instr_q;
  assign opA             = opa_q;
  assign opB             = opb_q;
  assign writeToMemData  = wmd_q;
  assign stall_count     = stall_q;

endmodule

// File: tb/tb_operand_collector.sv
// Scenario bench for operand_collector; expected slot contents are queued at acceptance and checked on consume.
module tb_operand_collector;

  localparam int W  = 32;
  localparam int NF = 3;
  localparam int RB = 5;
  localparam int CB = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic            in_ready, out_valid;
  logic [31:0]     instruction = '0, out_instruction;
  logic [W-1:0]    rsData = '0, rtData = '0, extendedImm = '0;
  logic [NF-1:0]   fwd_valid = '0, fwd_avail = '0;
  logic [NF*RB-1:0] fwd_reg = '0;
  logic [NF*W-1:0] fwd_data = '0;
  logic [W-1:0]    opA, opB, writeToMemData;
  logic [CB-1:0]   stall_count;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] w;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  operand_collector #(.WIDTH(W), .NUM_FWD(NF), .REG_BITS(RB), .CNT_BITS(CB)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .rsData(rsData), .rtData(rtData), .extendedImm(extendedImm),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_avail(fwd_avail), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .opA(opA), .opB(opB), .writeToMemData(writeToMemData), .stall_count(stall_count)
  );

  // Every slot handed to EX must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected: got instr=%h opA=%h, required no output", out_instruction, opA);
      end else begin
        mon_e = sb.pop_front();
        if (out_instruction !== mon_e.instr || opA !== mon_e.a || opB !== mon_e.b ||
            writeToMemData !== mon_e.w) begin
          n_fail++;
          $display("FAIL scoreboard: got instr=%h opA=%h opB=%h wmd=%h, required instr=%h opA=%h opB=%h wmd=%h",
                   out_instruction, opA, opB, writeToMemData, mon_e.instr, mon_e.a, mon_e.b, mon_e.w);
        end
      end
    end
  end

  function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [4:0] r, input logic a, input logic [31:0] d);
    fwd_valid[ch]           = v;
    fwd_reg[ch*RB +: RB]    = r;
    fwd_avail[ch]           = a;
    fwd_data[ch*W +: W]     = d;
  endtask

  task automatic clear_fwd();
    fwd_valid = '0;
    fwd_reg   = '0;
    fwd_avail = '0;
    fwd_data  = '0;
  endtask

  // Offer one instruction, queue its expectation when accepted; returns one step after the capture edge.
  task automatic send(input logic [31:0] ins, a, b, w);
    exp_t e;
    instruction = ins;
    in_valid    = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e.instr = ins; e.a = a; e.b = b; e.w = w;
        sb.push_back(e);
        tick();
        return;
      end
      tick();
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_timeout: instr=%h never accepted, required acceptance within 20 cycles", ins);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    instruction = r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    repeat (3) tick();
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks += 7;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
    if (out_instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h, required 0", out_instruction); end
    if (opA !== 32'h0) begin n_fail++; $display("FAIL reset_opA: got %h, required 0", opA); end
    if (opB !== 32'h0) begin n_fail++; $display("FAIL reset_opB: got %h, required 0", opB); end
    if (writeToMemData !== 32'h0) begin n_fail++; $display("FAIL reset_wmd: got %h, required 0", writeToMemData); end
    if (stall_count !== 4'h0) begin n_fail++; $display("FAIL reset_stall: got %h, required 0", stall_count); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_priority();
    tick();
    rsData = 32'h1234; rtData = 32'h5678; extendedImm = 32'h0;
    clear_fwd();
    set_ch(0, 1'b1, 5'd1, 1'b1, 32'hAAAA0000);
    set_ch(2, 1'b1, 5'd1, 1'b1, 32'h11111111);
    send(r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'hAAAA0000, 32'h5678, 32'h5678);
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL priority_latency: out_valid got %b, required 1", out_valid); end
    tick();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL priority_drain: out_valid got %b, required 0", out_valid); end
  endtask

  task automatic test_load_use();
    exp_t e;
    logic [31:0] sw = i_type(6'h2b, 5'd1, 5'd2, 16'd4);
    tick();
    clear_fwd();
    set_ch(0, 1'b1, 5'd2, 1'b0, 32'hDEAD0002);
    set_ch(1, 1'b1, 5'd2, 1'b1, 32'h0BAD0001);
    rsData = 32'h100; rtData = 32'h99; extendedImm = 32'd4;
    instruction = sw; in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks += 2;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL loaduse_stall%0d: in_ready got %b, required 0", c, in_ready); end
      if (stall_count !== CB'(c)) begin n_fail++; $display("FAIL loaduse_count%0d: got %0d, required %0d", c, stall_count, c); end
      tick();
    end
    fwd_avail[0] = 1'b1;
    @(negedge clk);
    n_checks += 2;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL loaduse_release: in_ready got %b, required 1", in_ready); end
    if (stall_count !== 4'd2) begin n_fail++; $display("FAIL loaduse_total: got %0d, required 2", stall_count); end
    e.instr = sw; e.a = 32'h100; e.b = 32'd4; e.w = 32'hDEAD0002;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    clear_fwd();
    @(negedge clk);
    n_checks++;
    if (stall_count !== 4'd2) begin n_fail++; $display("FAIL loaduse_hold: got %0d, required 2", stall_count); end
  endtask

  task automatic test_shift_zero();
    exp_t e;
    logic [31:0] sll = r_type(5'd0, 5'd0, 5'd4, 5'd7, 6'h00);
    tick();
    set_ch(0, 1'b1, 5'd0, 1'b0, 32'hBEEF);
    rsData = 32'h55; rtData = 32'h77;
    instruction = sll; in_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_nostall: in_ready got %b, required 1", in_ready); end
    e.instr = sll; e.a = 32'd7; e.b = 32'h77; e.w = 32'h77;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    clear_fwd();
    @(negedge clk);
    n_checks++;
    if (stall_count !== 4'd2) begin n_fail++; $display("FAIL zero_count: got %0d, required 2", stall_count); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [31:0] i1 = i_type(6'h08, 5'd6, 5'd5, 16'hFFFD);
    logic [31:0] i2 = i_type(6'h0d, 5'd8, 5'd7, 16'h8001);
    tick();
    out_ready = 1'b0;
    rsData = 32'h1000; rtData = 32'h2000; extendedImm = 32'hFFFFFFFD;
    send(i1, 32'h1000, 32'hFFFFFFFD, 32'h2000);
    rsData = 32'h3000; rtData = 32'h4000; extendedImm = 32'hFFFF8001;
    instruction = i2; in_valid = 1'b1;
    @(negedge clk);
    n_checks += 3;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b, required 0", in_ready); end
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b, required 1", out_valid); end
    if (out_instruction !== i1) begin n_fail++; $display("FAIL bp_instr: got %h, required %h", out_instruction, i1); end
    tick();
    rsData = 32'h3333; rtData = 32'h4444;
    @(negedge clk);
    n_checks += 5;
    if (out_instruction !== i1) begin n_fail++; $display("FAIL bp_hold_instr: got %h, required %h", out_instruction, i1); end
    if (opA !== 32'h1000) begin n_fail++; $display("FAIL bp_hold_opA: got %h, required 00001000", opA); end
    if (opB !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL bp_hold_opB: got %h, required fffffffd", opB); end
    if (writeToMemData !== 32'h2000) begin n_fail++; $display("FAIL bp_hold_wmd: got %h, required 00002000", writeToMemData); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready: got %b, required 0", in_ready); end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: in_ready got %b, required 1", in_ready); end
    e.instr = i2; e.a = 32'h3333; e.b = 32'h8001; e.w = 32'h4444;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second: out_valid got %b, required 1", out_valid); end
  endtask

  task automatic test_flush();
    logic [31:0] i3 = i_type(6'h0e, 5'd1, 5'd2, 16'h00F0);
    tick();
    out_ready = 1'b0;
    rsData = 32'h1; rtData = 32'h2; extendedImm = 32'hF0;
    send(i3, 32'h1, 32'hF0, 32'h2);
    instruction = r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b, required 1", in_ready); end
    tick();
    set_ch(0, 1'b1, 5'd1, 1'b0, 32'h0);
    @(negedge clk);
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b, required 0", out_valid); end
    if (stall_count !== 4'd2) begin n_fail++; $display("FAIL flush_count: got %0d, required 2", stall_count); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    clear_fwd();
    @(negedge clk);
    n_checks += 2;
    if (stall_count !== 4'd2) begin n_fail++; $display("FAIL flush_hazard_count: got %0d, required 2", stall_count); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: out_valid got %b, required 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    tick();
    out_ready = 1'b1;
    rsData = 32'h11; rtData = 32'h22; extendedImm = 32'hFFFF8001;
    set_ch(0, 1'b1, 5'd1, 1'b0, 32'hCAFE);
    send(32'h08200010, 32'h0, 32'h0, 32'h22);
    send(i_type(6'h0f, 5'd1, 5'd9, 16'h8001), 32'hCAFE, 32'h8001, 32'h22);
    clear_fwd();
    send(i_type(6'h07, 5'd1, 5'd0, 16'h0005), 32'h11, 32'h0, 32'h22);
    send(i_type(6'h3f, 5'd1, 5'd2, 16'h1234), 32'h11, 32'h0, 32'h22);
    send(i_type(6'h23, 5'd1, 5'd2, 16'h8001), 32'h11, 32'hFFFF8001, 32'h22);
    send(i_type(6'h0c, 5'd1, 5'd2, 16'h8001), 32'h11, 32'h8001, 32'h22);
    send(i_type(6'h04, 5'd1, 5'd2, 16'h8001), 32'h11, 32'h22, 32'h22);
    in_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    n_checks++;
    if (stall_count !== 4'd2) begin n_fail++; $display("FAIL b2b_count: got %0d, required 2", stall_count); end
  endtask

  task automatic test_stall_sat();
    tick();
    set_ch(0, 1'b1, 5'd1, 1'b0, 32'h0);
    instruction = r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    in_valid = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    n_checks += 2;
    if (stall_count !== 4'hF) begin n_fail++; $display("FAIL sat_count: got %0d, required 15", stall_count); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL sat_ready: got %b, required 0", in_ready); end
    tick();
    in_valid = 1'b0;
    clear_fwd();
  endtask

  task automatic test_reset_mid_hold();
    tick();
    out_ready = 1'b0;
    rsData = 32'h77; rtData = 32'h88;
    instruction = r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    in_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_hold_accept: in_ready got %b, required 1", in_ready); end
    tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_valid: got %b, required 0", out_valid); end
    if (out_instruction !== 32'h0) begin n_fail++; $display("FAIL rst_hold_instr: got %h, required 0", out_instruction); end
    if (opA !== 32'h0) begin n_fail++; $display("FAIL rst_hold_opA: got %h, required 0", opA); end
    if (stall_count !== 4'h0) begin n_fail++; $display("FAIL rst_hold_count: got %0d, required 0", stall_count); end
    tick();
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_load_use();
    test_shift_zero();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_stall_sat();
    test_reset_mid_hold();
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
